// File: rtl/bank_ram_pkg.sv
// bank_ram_pkg: shared width helpers and defaults for the interleaved bank memory
package bank_ram_pkg;

    localparam int STALL_MAX_DEF = 3;

    function automatic int addr_w(input int nbank, input int nword);
        return $clog2(nbank) + $clog2(nword);
    endfunction

    function automatic int cnt_w(input int smax);
        return $clog2(smax + 1);
    endfunction

endpackage

// File: rtl/bank_ram_bank.sv
// bank_ram_bank: one single-port bank with per-lane write mask and 1-cycle registered read
module bank_ram_bank #(
    parameter int SRAM_BIT  = 8,
    parameter int SRAM_BYTE = 16,
    parameter int SRAM_WORD = 64,
    parameter int FUNC_SIM  = 1,
    localparam int ROW_W    = $clog2(SRAM_WORD),
    localparam int W        = SRAM_BIT * SRAM_BYTE
) (
    input  logic                 clk,
    input  logic                 i_ce,
    input  logic                 i_we,
    input  logic [ROW_W-1:0]     i_row,
    input  logic [W-1:0]         i_wdata,
    input  logic [SRAM_BYTE-1:0] i_be,
    output logic [W-1:0]         o_rdata
);

    if (FUNC_SIM != 0) begin : g_beh
        logic [W-1:0] r_mem [SRAM_WORD];
        logic [W-1:0] r_q;
        // lane-wise write or registered read, only when the bank is enabled
        always_ff @(posedge clk) begin
            if (i_ce) begin
                if (i_we) begin
                    for (int l = 0; l < SRAM_BYTE; l++)
                        if (i_be[l]) r_mem[i_row][l*SRAM_BIT +: SRAM_BIT] <= i_wdata[l*SRAM_BIT +: SRAM_BIT];
                end else begin
                    r_q <= r_mem[i_row];
                end
            end
        end
        assign o_rdata = r_q;
    end else begin : g_mac
        logic [W-1:0] r_mem [SRAM_WORD];
        logic [W-1:0] r_q;
        logic [W-1:0] w_mask;
        // expand byte enables into the bit-write-enable form a macro expects
        always_comb begin
            w_mask = '0;
            for (int l = 0; l < SRAM_BYTE; l++)
                w_mask[l*SRAM_BIT +: SRAM_BIT] = {SRAM_BIT{i_be[l]}};
        end
        // bit-masked read-modify-write model of the macro port
        always_ff @(posedge clk) begin
            if (i_ce && i_we) r_mem[i_row] <= (r_mem[i_row] & ~w_mask) | (i_wdata & w_mask);
            if (i_ce && !i_we) r_q <= r_mem[i_row];
        end
        assign o_rdata = r_q;
    end

endmodule

// File: rtl/bank_ram.sv
// bank_ram: low-order interleaved multi-bank RAM with read-starvation-limited arbitration
module bank_ram
    import bank_ram_pkg::*;
#(
    parameter int SRAM_BIT    = 8,
    parameter int SRAM_BYTE   = 16,
    parameter int SRAM_WORD   = 64,
    parameter int NUM_BANK    = 4,
    parameter int STALL_MAX   = STALL_MAX_DEF,
    parameter int FUNC_SIM    = 1,
    localparam int BANK_W     = $clog2(NUM_BANK),
    localparam int ROW_W      = $clog2(SRAM_WORD),
    localparam int ADDR_W     = addr_w(NUM_BANK, SRAM_WORD),
    localparam int SRAM_WIDTH = SRAM_BIT * SRAM_BYTE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_vld,
    output logic                  wr_rdy,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [SRAM_WIDTH-1:0] wr_data,
    input  logic [SRAM_BYTE-1:0]  wr_be,
    input  logic                  rd_vld,
    output logic                  rd_rdy,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rdata_vld,
    output logic [SRAM_WIDTH-1:0] rdata
);

    localparam int CNT_W = cnt_w(STALL_MAX);
    localparam logic [CNT_W-1:0] SMAX = CNT_W'(STALL_MAX);

    logic [BANK_W-1:0]     w_wr_bank, w_rd_bank, r_rbank;
    logic [ROW_W-1:0]      w_wr_row, w_rd_row;
    logic                  w_conf, w_wr_acc, w_rd_acc, r_rvld;
    logic [CNT_W-1:0]      r_stall;
    logic [SRAM_WIDTH-1:0] r_hold;
    logic [SRAM_WIDTH-1:0] w_q [NUM_BANK];

    assign w_wr_bank = wr_addr[BANK_W-1:0];
    assign w_rd_bank = rd_addr[BANK_W-1:0];
    assign w_wr_row  = wr_addr[ADDR_W-1:BANK_W];
    assign w_rd_row  = rd_addr[ADDR_W-1:BANK_W];

    // write wins a same-bank clash until the read has waited STALL_MAX times
    always_comb begin
        w_conf   = wr_vld && rd_vld && (w_wr_bank == w_rd_bank);
        wr_rdy   = !w_conf || (r_stall != SMAX);
        rd_rdy   = !w_conf || (r_stall == SMAX);
        w_wr_acc = wr_vld && wr_rdy;
        w_rd_acc = rd_vld && rd_rdy;
    end

    // count consecutive lost clashes; any accepted read resets the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stall <= '0;
        else if (w_rd_acc) r_stall <= '0;
        else if (w_conf) r_stall <= r_stall + 1'b1;
    end

    // response tracking: remember which bank answers and keep the last data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvld  <= 1'b0;
            r_rbank <= '0;
            r_hold  <= '0;
        end else begin
            r_rvld <= w_rd_acc;
            if (w_rd_acc) r_rbank <= w_rd_bank;
            if (r_rvld) r_hold <= w_q[r_rbank];
        end
    end

    assign rdata_vld = r_rvld;
    assign rdata     = r_rvld ? w_q[r_rbank] : r_hold;

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic w_we, w_re;
        assign w_we = w_wr_acc && (w_wr_bank == BANK_W'(b));
        assign w_re = w_rd_acc && (w_rd_bank == BANK_W'(b));
        bank_ram_bank #(
            .SRAM_BIT (SRAM_BIT),
            .SRAM_BYTE(SRAM_BYTE),
            .SRAM_WORD(SRAM_WORD),
            .FUNC_SIM (FUNC_SIM)
        ) u_bank (
            .clk    (clk),
            .i_ce   (w_we || w_re),
            .i_we   (w_we),
            .i_row  (w_we ? w_wr_row : w_rd_row),
            .i_wdata(wr_data),
            .i_be   (wr_be),
            .o_rdata(w_q[b])
        );
    end

endmodule

// File: tb/tb_bank_ram.sv
// tb_bank_ram: directed scenarios plus random traffic checked by a response scoreboard
module tb_bank_ram;

    localparam int BIT = 8, BYTE = 16, WORD = 64, NB = 4, SMAX = 3;
    localparam int BW = 2, AW = 8, W = BIT * BYTE;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          wr_vld = 1'b0, rd_vld = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [BYTE-1:0] wr_be = '0;
    logic          wr_rdy, rd_rdy, rdata_vld;
    logic [W-1:0]  rdata;

    int checks = 0, errors = 0;
    bit mon_en = 1'b0;
    int m_stall = 0, stall_run = 0;
    logic [W-1:0] model [NB*WORD];
    logic [W-1:0] exp_q [$];

    bank_ram #(.SRAM_BIT(BIT), .SRAM_BYTE(BYTE), .SRAM_WORD(WORD), .NUM_BANK(NB), .STALL_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
        .rdata_vld(rdata_vld), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // scoreboard: check handshake against a stall model, pop responses, push accepted reads
    always @(negedge clk) begin
        if (!rst_n) begin
            m_stall = 0;
            stall_run = 0;
        end else begin
            bit conf, ewr, erd, wacc, racc;
            logic [W-1:0] e;
            conf = wr_vld && rd_vld && (wr_addr[BW-1:0] == rd_addr[BW-1:0]);
            ewr = !conf || (m_stall < SMAX);
            erd = !conf || (m_stall == SMAX);
            checks++;
            if (wr_rdy !== ewr || rd_rdy !== erd) begin
                errors++;
                $display("FAIL rdy: wr_rdy=%b rd_rdy=%b required %b %b", wr_rdy, rd_rdy, ewr, erd);
            end
            wacc = wr_vld && wr_rdy;
            racc = rd_vld && rd_rdy;
            if (mon_en) begin
                checks++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (rdata_vld !== 1'b1 || rdata !== e) begin
                        errors++;
                        $display("FAIL resp: vld=%b rdata=%h required vld=1 rdata=%h", rdata_vld, rdata, e);
                    end
                end else if (rdata_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious: rdata_vld=%b required 0", rdata_vld);
                end
                if (racc) exp_q.push_back(model[rd_addr]);
            end
            if (wacc)
                for (int l = 0; l < BYTE; l++)
                    if (wr_be[l]) model[wr_addr][l*BIT +: BIT] = wr_data[l*BIT +: BIT];
            m_stall = racc ? 0 : (conf ? m_stall + 1 : m_stall);
            stall_run = (rd_vld && !rd_rdy) ? stall_run + 1 : 0;
            if (stall_run > SMAX) begin
                errors++;
                $display("FAIL starve: read stalled %0d cycles, limit %0d", stall_run, SMAX);
            end
        end
    end

    task automatic drive(input bit wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic [BYTE-1:0] be, input bit rv, input logic [AW-1:0] ra);
        @(posedge clk);
        #1;
        wr_vld = wv; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_vld = rv; rd_addr = ra;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, '0, 0, '0);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdata_vld !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_state: vld=%b rdata=%h required 0 0", rdata_vld, rdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < NB*WORD; a++) begin
            wr_vld = 1'b1; wr_addr = AW'(a); wr_data = '0; wr_be = '1;
            @(posedge clk);
            #1;
        end
        wr_vld = 1'b0;
        idle(1);
        mon_en = 1'b1;
    endtask

    task automatic test_write_read;
        logic [W-1:0] e = {16{8'hAA}};
        drive(1, 8'd5, e, '1, 0, '0);
        drive(0, '0, '0, '0, 1, 8'd5);
        idle(1);
        @(negedge clk);
        checks++;
        if (rdata_vld !== 1'b1 || rdata !== e) begin
            errors++;
            $display("FAIL write_read: vld=%b rdata=%h required 1 %h", rdata_vld, rdata, e);
        end
        idle(1);
    endtask

    task automatic test_parallel;
        drive(1, 8'd4, {16{8'h5A}}, '1, 1, 8'd9);
        @(negedge clk);
        checks++;
        if (wr_rdy !== 1'b1 || rd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL parallel_rdy: wr_rdy=%b rd_rdy=%b required 1 1", wr_rdy, rd_rdy);
        end
        idle(1);
        @(negedge clk);
        checks++;
        if (rdata_vld !== 1'b1 || rdata !== '0) begin
            errors++;
            $display("FAIL parallel_resp: vld=%b rdata=%h required 1 0", rdata_vld, rdata);
        end
        idle(1);
    endtask

    task automatic test_conflict;
        bit ew [5] = '{1, 1, 1, 0, 1};
        bit er [5] = '{0, 0, 0, 1, 0};
        drive(1, 8'd2, {16{8'h33}}, '1, 1, 8'd6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (wr_rdy !== ew[i] || rd_rdy !== er[i]) begin
                errors++;
                $display("FAIL conflict[%0d]: wr_rdy=%b rd_rdy=%b required %b %b", i, wr_rdy, rd_rdy, ew[i], er[i]);
            end
            @(posedge clk);
        end
        #1;
        idle(2);
    endtask

    task automatic test_byte_enable;
        logic [W-1:0] e = {{15{8'hFF}}, 8'h00};
        drive(1, 8'd7, '1, '1, 0, '0);
        drive(1, 8'd7, '0, 16'h0001, 0, '0);
        drive(1, 8'd7, '0, 16'h0000, 0, '0);
        drive(0, '0, '0, '0, 1, 8'd7);
        idle(1);
        @(negedge clk);
        checks++;
        if (rdata_vld !== 1'b1 || rdata !== e) begin
            errors++;
            $display("FAIL byte_enable: vld=%b rdata=%h required 1 %h", rdata_vld, rdata, e);
        end
        idle(1);
    endtask

    task automatic test_reset_inflight;
        mon_en = 1'b0;
        drive(0, '0, '0, '0, 1, 8'd5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rd_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (rdata_vld !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_inflight: vld=%b rdata=%h required 0 0", rdata_vld, rdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (rdata_vld !== 1'b0) begin
                errors++;
                $display("FAIL reset_drop[%0d]: rdata_vld=%b required 0", i, rdata_vld);
            end
        end
        mon_en = 1'b1;
        drive(0, '0, '0, '0, 1, 8'd5);
        idle(1);
        @(negedge clk);
        checks++;
        if (rdata_vld !== 1'b1 || rdata !== {16{8'hAA}}) begin
            errors++;
            $display("FAIL reset_keep: vld=%b rdata=%h required 1 %h", rdata_vld, rdata, {16{8'hAA}});
        end
        idle(1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 10000; i++)
            drive(1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  BYTE'($urandom), 1'($urandom_range(0, 1)), AW'($urandom));
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_parallel;
        test_conflict;
        test_byte_enable;
        test_reset_inflight;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_ram.md
BANK_RAM -- requirements
Module: bank_ram

Interface
REQ-001 SHALL have parameter SRAM_BIT, default 8, meaning bits per byte lane.
REQ-002 SHALL have parameter SRAM_BYTE, default 16, meaning byte lanes per word; SRAM_WIDTH = SRAM_BIT*SRAM_BYTE.
REQ-003 SHALL have parameter SRAM_WORD, default 64, meaning words per bank (power of two).
REQ-004 SHALL have parameter NUM_BANK, default 4, meaning interleaved single-port banks (power of two, >=2).
REQ-005 SHALL have parameter STALL_MAX, default 3, meaning consecutive read stalls before read is given priority (>=1).
REQ-006 SHALL derive BANK_W = $clog2(NUM_BANK), ROW_W = $clog2(SRAM_WORD), ADDR_W = BANK_W+ROW_W.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports wr_vld (in, 1), wr_rdy (out, 1), wr_addr (in, ADDR_W), wr_data (in, SRAM_WIDTH), wr_be (in, SRAM_BYTE): write request, byte enables.
REQ-010 SHALL have ports rd_vld (in, 1), rd_rdy (out, 1), rd_addr (in, ADDR_W): read request.
REQ-011 SHALL have ports rdata_vld (out, 1), rdata (out, SRAM_WIDTH): read response.

Function
REQ-012 SHALL map address as bank = addr[BANK_W-1:0], row = addr[ADDR_W-1:BANK_W] (low-order interleave).
REQ-013 SHALL accept a request only on its vld&&rdy cycle; rdy is combinational from vld, addresses and stall counter.
REQ-014 SHALL, when read and write target different banks, accept both in the same cycle.
REQ-015 SHALL, on same-bank conflict with stall_cnt < STALL_MAX, grant write (wr_rdy=1, rd_rdy=0) and increment stall_cnt.
REQ-016 SHALL, on same-bank conflict with stall_cnt == STALL_MAX, grant read (rd_rdy=1, wr_rdy=0).
REQ-017 SHALL clear stall_cnt to 0 on every accepted read; hold it when no conflict and no read accepted.
REQ-018 SHALL keep rd_rdy=1 and wr_rdy=1 whenever their request has no conflict.
REQ-019 SHALL write only lanes whose wr_be bit is 1; wr_be = 0 is an accepted no-op write.
REQ-020 SHALL assert rdata_vld exactly 1 cycle after read acceptance, for 1 cycle per accepted read; back-to-back reads give back-to-back responses.
REQ-021 SHALL drive rdata with fresh bank output when rdata_vld=1 and hold the last returned value otherwise.
REQ-022 SHALL return newly written data for a read accepted in any cycle after the write acceptance cycle (write-then-read = 1-cycle turnaround).
REQ-023 SHALL have no backpressure on responses; the consumer always accepts rdata.
REQ-024 SHALL gate each bank's chip enable so an idle bank performs no access.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear rdata_vld, rdata, stall_cnt and any in-flight response to 0.
REQ-026 SHALL drop a read accepted in the cycle reset asserts; no response after reset release.
REQ-027 SHALL NOT clear bank contents on reset.
REQ-028 SHALL accept requests in the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place derived-width helpers and the STALL_MAX default in the shared memory package.
REQ-030 SHALL instantiate NUM_BANK copies of sub-module bank_ram_bank (one single-port bank, per-lane write mask, 1-cycle read, FUNC_SIM behavioural or macro selection inside).
REQ-031 SHALL keep arbitration, stall counter and response register in bank_ram top.

Verification
REQ-032 Write 0xAA.. to addr 5 full be, read addr 5 next cycle -> rdata_vld 1 cycle later, rdata = 0xAA...
REQ-033 Write addr 4 (bank 0) and read addr 9 (bank 1) same cycle -> wr_rdy=rd_rdy=1, response valid next cycle.
REQ-034 Continuous writes and reads both to bank 2 -> write granted 3 cycles, read granted 4th, stall_cnt returns 0.
REQ-035 Write all-ones, then write 0 with wr_be=0x0001 -> read returns lane 0 = 0x00, all other lanes 0xFF.
REQ-036 rst_n low in cycle after read acceptance -> rdata_vld stays 0, rdata = 0; post-reset read of earlier written addr returns stored data.
REQ-037 Random vld/addr/be traffic 10k cycles against scoreboard model -> zero mismatches, no read stalled more than STALL_MAX cycles.
